// File: rtl/divrem_pkg.sv
// Shared types and constants for the sequential signed divider.
package divrem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_REM = 1'b0;
  localparam logic OP_QUO = 1'b1;

  // Iteration counter width: must hold WIDTH-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/divrem_step.sv
// One restoring-division iteration on unsigned magnitudes.
module divrem_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next_c,
  output logic [WIDTH-1:0] quo_next_c
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;

  // Shift the {rem, quo} pair left, trial-subtract, restore on borrow.
  always_comb begin
    sh         = {rem, quo[WIDTH-1]};
    diff       = sh - {1'b0, dvs};
    rem_next_c = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_next_c = {quo[WIDTH-2:0], ~diff[WIDTH]};
  end

endmodule

// File: rtl/seq_divrem.sv
// Multi-cycle signed divider/remainder with start/valid handshake and flags.
module seq_divrem
  import divrem_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] Y,
  output logic             SF,
  output logic             ZF,
  output logic             DZF,
  output logic             OVF
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] rem, rem_n;
  logic [WIDTH-1:0] quo, quo_n;
  logic [WIDTH-1:0] dvs, dvs_n;
  logic             sign_a, sign_a_n;
  logic             neg_q, neg_q_n;
  logic             op_q, op_q_n;
  logic             busy_n, valid_n;
  logic [WIDTH-1:0] y_n;
  logic             sf_n, zf_n, dzf_n, ovf_n;

  logic [WIDTH-1:0] step_rem_c, step_quo_c;
  logic [WIDTH-1:0] q_fix_c, r_fix_c, res_c;

  divrem_step #(.WIDTH(WIDTH)) u_step (
    .rem        (rem),
    .quo        (quo),
    .dvs        (dvs),
    .rem_next_c (step_rem_c),
    .quo_next_c (step_quo_c)
  );

  // Sign-correct the result of the final iteration and select by op.
  always_comb begin
    q_fix_c = neg_q  ? (~step_quo_c + WIDTH'(1)) : step_quo_c;
    r_fix_c = sign_a ? (~step_rem_c + WIDTH'(1)) : step_rem_c;
    res_c   = (op_q == OP_QUO) ? q_fix_c : r_fix_c;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      sign_a <= 1'b0;
      neg_q  <= 1'b0;
      op_q   <= 1'b0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      Y      <= '0;
      SF     <= 1'b0;
      ZF     <= 1'b0;
      DZF    <= 1'b0;
      OVF    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rem    <= rem_n;
      quo    <= quo_n;
      dvs    <= dvs_n;
      sign_a <= sign_a_n;
      neg_q  <= neg_q_n;
      op_q   <= op_q_n;
      busy   <= busy_n;
      valid  <= valid_n;
      Y      <= y_n;
      SF     <= sf_n;
      ZF     <= zf_n;
      DZF    <= dzf_n;
      OVF    <= ovf_n;
    end
  end

  // Next-state, iteration and result logic.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rem_n    = rem;
    quo_n    = quo;
    dvs_n    = dvs;
    sign_a_n = sign_a;
    neg_q_n  = neg_q;
    op_q_n   = op_q;
    y_n      = Y;
    sf_n     = SF;
    zf_n     = ZF;
    dzf_n    = DZF;
    ovf_n    = OVF;

    case (state)
      IDLE: begin
        if (start) begin
          op_q_n = op;
          if (B == '0) begin
            state_n = DONE;
            y_n     = '0;
            sf_n    = 1'b0;
            zf_n    = 1'b0;
            dzf_n   = 1'b1;
            ovf_n   = 1'b0;
          end else begin
            state_n  = CALC;
            rem_n    = '0;
            // |most-negative| equals its own bit pattern read as unsigned.
            quo_n    = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
            dvs_n    = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;
            sign_a_n = A[WIDTH-1];
            neg_q_n  = A[WIDTH-1] ^ B[WIDTH-1];
            cnt_n    = CW'(WIDTH - 1);
          end
        end
      end
      CALC: begin
        rem_n = step_rem_c;
        quo_n = step_quo_c;
        cnt_n = cnt - CW'(1);
        if (cnt == '0) begin
          state_n = DONE;
          y_n     = res_c;
          sf_n    = res_c[WIDTH-1];
          zf_n    = (res_c == '0);
          dzf_n   = 1'b0;
          // Unsigned quotient magnitude reaches 2^(WIDTH-1) without negation
          // only for most-negative / -1.
          ovf_n   = (op_q == OP_QUO) && !neg_q && step_quo_c[WIDTH-1];
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    valid_n = (state_n == DONE);
    busy_n  = (state_n != IDLE);
  end

endmodule

// File: tb/tb_seq_divrem.sv
// Self-checking bench for seq_divrem at WIDTH=8 (directed) and WIDTH=3 (exhaustive).
module tb_seq_divrem;

  typedef struct {
    int          k;
    int          due;
    logic [31:0] y;
    logic        sf;
    logic        zf;
    logic        dzf;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic       start8 = 1'b0, op8 = 1'b0;
  logic [7:0] A8 = '0, B8 = '0;
  logic       busy8, valid8, SF8, ZF8, DZF8, OVF8;
  logic [7:0] Y8;

  logic       start3 = 1'b0, op3 = 1'b0;
  logic [2:0] A3 = '0, B3 = '0;
  logic       busy3, valid3, SF3, ZF3, DZF3, OVF3;
  logic [2:0] Y3;

  exp_t q8[$];
  exp_t q3[$];

  seq_divrem #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .A(A8), .B(B8),
    .busy(busy8), .valid(valid8), .Y(Y8), .SF(SF8), .ZF(ZF8), .DZF(DZF8), .OVF(OVF8)
  );

  seq_divrem #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .op(op3), .A(A3), .B(B3),
    .busy(busy3), .valid(valid3), .Y(Y3), .SF(SF3), .ZF(ZF3), .DZF(DZF3), .OVF(OVF3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain signed arithmetic, result wrapped to w bits.
  function automatic exp_t model(input int w, input int a, input int b, input bit o, input int k);
    exp_t e;
    int   v;
    int   ym;
    e.k = k;
    if (b == 0) begin
      e.due = k + 1;
      e.y = '0; e.sf = 1'b0; e.zf = 1'b0; e.dzf = 1'b1; e.ovf = 1'b0;
    end else begin
      v     = o ? (a / b) : (a % b);
      ym    = v & ((1 << w) - 1);
      e.due = k + 1 + w;
      e.y   = 32'(ym);
      e.sf  = ((ym >> (w - 1)) & 1) != 0;
      e.zf  = (ym == 0);
      e.dzf = 1'b0;
      e.ovf = o && (v == (1 << (w - 1)));
    end
    return e;
  endfunction

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle check of one DUT against the head of its expectation queue.
  task automatic chk(input string tag, input bit have, input exp_t e,
                     input logic v, input logic bsy, input logic [31:0] y,
                     input logic sf, input logic zf, input logic dzf, input logic ovf,
                     output bit pop);
    bit due_now;
    bit exp_busy;
    due_now  = have && (e.due == cyc);
    exp_busy = have && (cyc > e.k) && (cyc <= e.due);
    pop = due_now;
    check_lit({tag, " valid"}, 32'(v), 32'(due_now));
    check_lit({tag, " busy"}, 32'(bsy), 32'(exp_busy));
    if (due_now) begin
      check_lit({tag, " Y"}, y, e.y);
      check_lit({tag, " SF"}, 32'(sf), 32'(e.sf));
      check_lit({tag, " ZF"}, 32'(zf), 32'(e.zf));
      check_lit({tag, " DZF"}, 32'(dzf), 32'(e.dzf));
      check_lit({tag, " OVF"}, 32'(ovf), 32'(e.ovf));
    end
  endtask

  // Compare both DUTs against the model every cycle out of reset.
  always @(negedge clk) begin
    bit   pop;
    exp_t e;
    if (rst_n) begin
      e = '{default: '0};
      if (q8.size() > 0) e = q8[0];
      chk("w8", q8.size() > 0, e, valid8, busy8, {24'b0, Y8}, SF8, ZF8, DZF8, OVF8, pop);
      if (pop) void'(q8.pop_front());
      e = '{default: '0};
      if (q3.size() > 0) e = q3[0];
      chk("w3", q3.size() > 0, e, valid3, busy3, {29'b0, Y3}, SF3, ZF3, DZF3, OVF3, pop);
      if (pop) void'(q3.pop_front());
    end
  end

  // Called at a falling edge; start is high for exactly one cycle.
  task automatic issue8(input int a, input int b, input bit o, input bit accept);
    A8 = 8'(a); B8 = 8'(b); op8 = o; start8 = 1'b1;
    if (accept) q8.push_back(model(8, a, b, o, cyc));
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic issue3(input int a, input int b, input bit o);
    A3 = 3'(a); B3 = 3'(b); op3 = o; start3 = 1'b1;
    q3.push_back(model(3, a, b, o, cyc));
    @(negedge clk);
    start3 = 1'b0;
  endtask

  task automatic check_held8(input string name, input logic [7:0] y, input logic sf,
                             input logic zf, input logic dzf, input logic ovf);
    check_lit({name, " Y"}, {24'b0, Y8}, {24'b0, y});
    check_lit({name, " SF"}, 32'(SF8), 32'(sf));
    check_lit({name, " ZF"}, 32'(ZF8), 32'(zf));
    check_lit({name, " DZF"}, 32'(DZF8), 32'(dzf));
    check_lit({name, " OVF"}, 32'(OVF8), 32'(ovf));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_lit("reset busy", 32'(busy8), 32'd0);
    check_lit("reset valid", 32'(valid8), 32'd0);
    check_held8("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Mixed-sign remainder and quotient; latency pinned by the compare process.
    issue8(7, -3, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    check_held8("7%-3", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    issue8(7, -3, 1'b1, 1'b1);
    repeat (9) @(negedge clk);
    check_held8("7/-3", 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);

    issue8(-7, 3, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    check_held8("-7%3", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    issue8(6, 3, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    check_held8("6%3", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Most-negative dividend by -1.
    issue8(-128, -1, 1'b1, 1'b1);
    repeat (9) @(negedge clk);
    check_held8("-128/-1", 8'h80, 1'b1, 1'b0, 1'b0, 1'b1);
    issue8(-128, -1, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    check_held8("-128%-1", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Divide by zero, with a second start during its busy (DONE) cycle.
    issue8(5, 0, 1'b0, 1'b1);
    issue8(9, 2, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check_held8("5/0", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Starts during CALC and during DONE are ignored.
    issue8(100, 7, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    issue8(1, 1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    issue8(3, 1, 1'b0, 1'b0);
    @(negedge clk);
    check_held8("100/7", 8'h0E, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset four cycles into an operation.
    issue8(50, 3, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    q8.delete();
    check_lit("midrst busy", 32'(busy8), 32'd0);
    check_lit("midrst valid", 32'(valid8), 32'd0);
    check_held8("midrst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue8(50, 3, 1'b1, 1'b1);
    repeat (9) @(negedge clk);
    check_held8("50/3", 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back starts at the maximum rate.
    issue8(-100, 9, 1'b1, 1'b1);
    repeat (9) @(negedge clk);
    issue8(-100, 9, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    check_held8("-100%9", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);

    // Exhaustive WIDTH=3 sweep at full throughput.
    for (int o = 0; o < 2; o++)
      for (int a = -4; a < 4; a++)
        for (int b = -4; b < 4; b++) begin
          issue3(a, b, o[0]);
          repeat (4) @(negedge clk);
        end

    repeat (12) @(negedge clk);
    check_lit("w8 pending", 32'(q8.size()), 32'd0);
    check_lit("w3 pending", 32'(q3.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
